// File: rtl/ledger_memory_responder.sv
// Memory-side responder: one 48-bit ledger word plus a circular store of 8-bit
// block hashes, with edge-triggered write commit/ack and a 2-stage read pipeline.
module ledger_memory_responder #(
    parameter int          DEPTH       = 16,
    parameter int          IDX_W       = 4,
    parameter logic [47:0] INIT_LEDGER = 48'h0,
    parameter logic [7:0]  HASH_SEED   = 8'hA5
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             write_enable,
    input  logic             access_type,
    input  logic [47:0]      data_in,
    output logic [47:0]      data_out,
    output logic             data_valid,
    output logic [7:0]       prev_hash,
    output logic [IDX_W-1:0] block_index,
    output logic             chain_full,
    output logic             write_ack,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, COMMIT, ACK, HOLD} state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic               lat_type_q, lat_type_d;
    logic [47:0]        lat_data_q, lat_data_d;
    logic [47:0]        ledger_q, ledger_d;
    logic [IDX_W-1:0]   block_index_q, block_index_d;
    logic               chain_full_q, chain_full_d;
    logic               sel_q, sel_d;
    logic [47:0]        data_out_q, data_out_d;
    logic [1:0]         settle_q, settle_d;
    logic [7:0]         hash_mem [DEPTH];

    logic               request;
    logic               hash_we;
    logic [IDX_W-1:0]   prev_idx;

    assign request  = write_enable & ~we_q;
    assign hash_we  = resetn && (state_q == COMMIT) && lat_type_q;
    assign prev_idx = block_index_q - IDX_W'(1);

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (request) state_d = COMMIT;
            COMMIT:  state_d = ACK;
            ACK:     state_d = write_enable ? HOLD : IDLE;
            HOLD:    if (!write_enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        write_ack = (state_q == ACK);
        busy      = (state_q != IDLE);
    end

    always_comb begin
        // Edge history tracks write_enable even while in reset, so a level still
        // held high when reset releases is not mistaken for a fresh request.
        we_d          = write_enable;
        lat_type_d    = lat_type_q;
        lat_data_d    = lat_data_q;
        ledger_d      = ledger_q;
        block_index_d = block_index_q;
        chain_full_d  = chain_full_q;
        if (state_q == IDLE && request) begin
            lat_type_d = access_type;
            lat_data_d = data_in;
        end
        if (state_q == COMMIT) begin
            if (!lat_type_q) begin
                ledger_d = lat_data_q;
            end else begin
                block_index_d = block_index_q + IDX_W'(1);
                if (block_index_q == IDX_W'(DEPTH - 1)) chain_full_d = 1'b1;
            end
        end
    end

    always_comb begin
        if (block_index_q == '0 && !chain_full_q) prev_hash = HASH_SEED;
        else                                      prev_hash = hash_mem[prev_idx];
    end

    // Read pipeline and settle counter; one reload covers coincident events.
    always_comb begin
        sel_d      = access_type;
        data_out_d = sel_q ? {40'b0, prev_hash} : ledger_q;
        settle_d   = settle_q;
        if (state_q == COMMIT || access_type != sel_q) settle_d = 2'd2;
        else if (settle_q != 2'd0)                     settle_d = settle_q - 2'd1;
    end

    always_ff @(posedge clock) begin
        we_q <= we_d;
        if (!resetn) begin
            lat_type_q    <= 1'b0;
            lat_data_q    <= '0;
            ledger_q      <= INIT_LEDGER;
            block_index_q <= '0;
            chain_full_q  <= 1'b0;
            sel_q         <= 1'b0;
            data_out_q    <= '0;
            settle_q      <= 2'd2;
        end else begin
            lat_type_q    <= lat_type_d;
            lat_data_q    <= lat_data_d;
            ledger_q      <= ledger_d;
            block_index_q <= block_index_d;
            chain_full_q  <= chain_full_d;
            sel_q         <= sel_d;
            data_out_q    <= data_out_d;
            settle_q      <= settle_d;
        end
    end

    // Hash store is intentionally never cleared.
    always_ff @(posedge clock) begin
        if (hash_we) hash_mem[block_index_q] <= lat_data_q[7:0];
    end

    assign data_out    = data_out_q;
    assign data_valid  = (settle_q == 2'd0);
    assign block_index = block_index_q;
    assign chain_full  = chain_full_q;

endmodule

// File: tb/tb_ledger_memory_responder.sv
// Directed bench for ledger_memory_responder: ledger/hash writes, wrap, reset
// during a held write, and read settle timing.
module tb_ledger_memory_responder;

    logic        clock;
    logic        resetn;
    logic        write_enable;
    logic        access_type;
    logic [47:0] data_in;
    logic [47:0] data_out;
    logic        data_valid;
    logic [7:0]  prev_hash;
    logic [3:0]  block_index;
    logic        chain_full;
    logic        write_ack;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;
    logic [47:0] exp_q[$];

    ledger_memory_responder #(
        .DEPTH(16), .IDX_W(4), .INIT_LEDGER(48'h0), .HASH_SEED(8'hA5)
    ) dut (
        .clock(clock), .resetn(resetn), .write_enable(write_enable),
        .access_type(access_type), .data_in(data_in), .data_out(data_out),
        .data_valid(data_valid), .prev_hash(prev_hash), .block_index(block_index),
        .chain_full(chain_full), .write_ack(write_ack), .busy(busy)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drivers
    task automatic do_write(input logic typ, input logic [47:0] val, input string tag);
        int acks;
        access_type  = typ;
        data_in      = val;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        data_in      = 48'($urandom_range(0, 32'hFFFF)) << 8;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (write_ack) begin
                acks++;
                break;
            end
        end
        check_val({tag, "_ack"}, 48'(acks), 48'd1);
        tick();
    endtask

    initial begin
        int acks;
        int busy_cnt;
        resetn       = 1'b0;
        write_enable = 1'b0;
        access_type  = 1'b0;
        data_in      = '0;
        tick();
        tick();
        check_val("rst_data_out", data_out, 48'h0);
        check_val("rst_valid", 48'(data_valid), 48'd0);
        check_val("rst_busy", 48'(busy), 48'd0);
        check_val("rst_ack", 48'(write_ack), 48'd0);
        check_val("rst_index", 48'(block_index), 48'd0);
        check_val("rst_full", 48'(chain_full), 48'd0);
        check_val("rst_prev", 48'(prev_hash), 48'hA5);

        // Seed hash read after reset
        resetn      = 1'b1;
        access_type = 1'b1;
        tick();
        tick();
        tick();
        check_val("seed_valid", 48'(data_valid), 48'd1);
        check_val("seed_data", data_out, 48'h0000000000A5);
        check_val("seed_busy", 48'(busy), 48'd0);

        // Ledger write with write_enable held 16 cycles
        access_type  = 1'b0;
        data_in      = 48'h123456789ABC;
        write_enable = 1'b1;
        acks = 0;
        busy_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (write_ack) begin
                acks++;
                check_val("led_ack_cycle", 48'(i), 48'd1);
            end
            if (busy) busy_cnt++;
            if (i == 2) check_val("led_settling", 48'(data_valid), 48'd0);
            if (i == 3) begin
                check_val("led_valid3", 48'(data_valid), 48'd1);
                check_val("led_data3", data_out, 48'h123456789ABC);
            end
        end
        check_val("led_acks", 48'(acks), 48'd1);
        check_val("led_busy_cnt", 48'(busy_cnt), 48'd16);
        write_enable = 1'b0;
        tick();
        check_val("led_busy_drop", 48'(busy), 48'd0);

        // Hash write with write_enable held 1024 cycles
        access_type  = 1'b1;
        data_in      = 48'hFFFF_FFFF_FF3C;
        write_enable = 1'b1;
        acks = 0;
        for (int i = 0; i < 1024; i++) begin
            tick();
            if (write_ack) acks++;
        end
        write_enable = 1'b0;
        tick();
        check_val("hash_acks", 48'(acks), 48'd1);
        check_val("hash_index", 48'(block_index), 48'd1);
        check_val("hash_prev", 48'(prev_hash), 48'h3C);
        tick();
        tick();
        check_val("hash_data", data_out, 48'h00000000003C);
        check_val("hash_valid", 48'(data_valid), 48'd1);

        // Sixteen single-cycle hash writes from a clean index, then a 17th
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 1; i <= 17; i++) exp_q.push_back(48'(i));
        for (int i = 1; i <= 16; i++) begin
            do_write(1'b1, 48'hABCD_0000_0000 | 48'(i), "wrap");
            check_val("wrap_prev", 48'(prev_hash), exp_q.pop_front());
            if (i == 15) begin
                check_val("wrap_idx15", 48'(block_index), 48'd15);
                check_val("wrap_notfull", 48'(chain_full), 48'd0);
            end
        end
        check_val("wrap_idx0", 48'(block_index), 48'd0);
        check_val("wrap_full", 48'(chain_full), 48'd1);
        tick();
        tick();
        check_val("wrap_data", data_out, 48'h10);
        do_write(1'b1, 48'h11, "w17");
        check_val("w17_prev", 48'(prev_hash), exp_q.pop_front());
        check_val("w17_idx", 48'(block_index), 48'd1);
        check_val("w17_full", 48'(chain_full), 48'd1);

        // Reset during HOLD after a ledger write
        access_type  = 1'b0;
        data_in      = 48'hABC;
        write_enable = 1'b1;
        tick();
        tick();
        tick();
        check_val("hold_busy", 48'(busy), 48'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check_val("rh_busy", 48'(busy), 48'd0);
        check_val("rh_index", 48'(block_index), 48'd0);
        check_val("rh_full", 48'(chain_full), 48'd0);
        check_val("rh_prev", 48'(prev_hash), 48'hA5);
        acks = 0;
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (write_ack) acks++;
            if (busy) busy_cnt++;
        end
        check_val("rh_no_ack", 48'(acks), 48'd0);
        check_val("rh_no_busy", 48'(busy_cnt), 48'd0);
        check_val("rh_ledger", data_out, 48'h0);
        write_enable = 1'b0;
        tick();
        do_write(1'b0, 48'h777, "rh_rewrite");
        tick();
        tick();
        check_val("rh_new_ledger", data_out, 48'h777);

        // Toggle access_type every cycle, then let it settle
        check_val("tog_pre_valid", 48'(data_valid), 48'd1);
        for (int i = 0; i < 10; i++) begin
            access_type = ~access_type;
            tick();
            check_val("tog_valid", 48'(data_valid), 48'd0);
        end
        tick();
        check_val("tog_settle1", 48'(data_valid), 48'd0);
        tick();
        check_val("tog_settle2", 48'(data_valid), 48'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
